// File: rtl/alu_flags_stage.sv
// alu_flags_stage
// Execute-to-memory stage register sitting right after the 64-bit ALU.
// Registers the ALU result, keeps the architectural NZCV flags for
// flag-setting instructions and turns conditional branches into a
// registered branch_taken. Stall holds everything; flush kills the slot.
// Optional feature macro: CBZ_EN enables CBZ/CBNZ decoding; without it
// is_cbz and is_cbnz are ignored and only B.cond can take a branch.
module alu_flags_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [63:0] alu_result,
    input  logic        alu_negative,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        alu_carry_out,
    input  logic        set_flags,
    input  logic        is_bcond,
    input  logic        is_cbz,
    input  logic        is_cbnz,
    input  logic [3:0]  cond,
    input  logic        stall,
    input  logic        flush,
    output logic        out_valid,
    output logic [63:0] out_result,
    output logic        branch_taken,
    output logic [3:0]  nzcv
);

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;
    logic cond_pass;
    logic taken_next;

    assign flag_n = nzcv[3];
    assign flag_z = nzcv[2];
    assign flag_c = nzcv[1];
    assign flag_v = nzcv[0];

    // Evaluate the B.cond condition against the flags held before this edge,
    // so a same-cycle flag update is deliberately not visible here.
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = !flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = !flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = !flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = !flag_v;
            4'b1000: cond_pass = flag_c && !flag_z;
            4'b1001: cond_pass = !flag_c || flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);
            default: cond_pass = 1'b1;
        endcase
    end

`ifdef CBZ_EN
    // Branch select: compare-and-branch uses the live ALU zero flag and
    // takes priority over B.cond (CBZ first, then CBNZ).
    always_comb begin
        taken_next = 1'b0;
        if (is_cbz) begin
            taken_next = alu_zero;
        end else if (is_cbnz) begin
            taken_next = !alu_zero;
        end else if (is_bcond) begin
            taken_next = cond_pass;
        end
    end
`else
    logic unused_cb_inputs;

    assign unused_cb_inputs = is_cbz ^ is_cbnz;

    // Branch select: without compare-and-branch support only B.cond counts.
    always_comb begin
        taken_next = 1'b0;
        if (is_bcond) begin
            taken_next = cond_pass;
        end
    end
`endif

    // Stage register: reset beats flush, flush beats stall, stall holds all.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_result   <= 64'd0;
            branch_taken <= 1'b0;
            nzcv         <= 4'b0000;
        end else if (flush) begin
            out_valid    <= 1'b0;
            out_result   <= 64'd0;
            branch_taken <= 1'b0;
        end else if (!stall) begin
            out_valid    <= in_valid;
            out_result   <= alu_result;
            branch_taken <= in_valid && taken_next;
            if (in_valid && set_flags) begin
                nzcv <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
            end
        end
    end

endmodule

// File: tb/tb_alu_flags_stage.sv
// tb_alu_flags_stage
// Directed self-checking bench for alu_flags_stage. Works with and without
// CBZ_EN defined; compare-and-branch expectations follow the macro.
module tb_alu_flags_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [63:0] alu_result;
    logic        alu_negative;
    logic        alu_zero;
    logic        alu_overflow;
    logic        alu_carry_out;
    logic        set_flags;
    logic        is_bcond;
    logic        is_cbz;
    logic        is_cbnz;
    logic [3:0]  cond;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [63:0] out_result;
    logic        branch_taken;
    logic [3:0]  nzcv;

    int tests_run;
    int tests_failed;

    alu_flags_stage dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .alu_result   (alu_result),
        .alu_negative (alu_negative),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .alu_carry_out(alu_carry_out),
        .set_flags    (set_flags),
        .is_bcond     (is_bcond),
        .is_cbz       (is_cbz),
        .is_cbnz      (is_cbnz),
        .cond         (cond),
        .stall        (stall),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_result   (out_result),
        .branch_taken (branch_taken),
        .nzcv         (nzcv)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge and settle 1 ns after it before anyone samples
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return all inputs to an idle, non-instruction state
    task automatic set_idle();
        reset         = 1'b0;
        in_valid      = 1'b0;
        alu_result    = 64'd0;
        alu_negative  = 1'b0;
        alu_zero      = 1'b0;
        alu_overflow  = 1'b0;
        alu_carry_out = 1'b0;
        set_flags     = 1'b0;
        is_bcond      = 1'b0;
        is_cbz        = 1'b0;
        is_cbnz       = 1'b0;
        cond          = 4'b0000;
        stall         = 1'b0;
        flush         = 1'b0;
    endtask

    // Load nzcv through a flag-setting instruction
    task automatic load_flags(input logic [3:0] f);
        set_idle();
        in_valid      = 1'b1;
        set_flags     = 1'b1;
        alu_negative  = f[3];
        alu_zero      = f[2];
        alu_carry_out = f[1];
        alu_overflow  = f[0];
        tick();
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
        end
        tests_run++;
        if (out_result !== 64'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_result: got %h want 0", out_result);
        end
        tests_run++;
        if (nzcv !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_nzcv: got %b want 0000", nzcv);
        end
        load_flags(4'b1111);
        tests_run++;
        if (nzcv !== 4'b1111) begin
            tests_failed++;
            $display("[TB] FAIL preload_nzcv: got %b want 1111", nzcv);
        end
        set_idle();
        in_valid   = 1'b1;
        is_bcond   = 1'b1;
        cond       = 4'b1110;
        alu_result = 64'h1234;
        tick();
        // mid-operation reset with in_valid and stall also high
        reset      = 1'b1;
        stall      = 1'b1;
        alu_result = 64'h5678;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_result !== 64'd0 || branch_taken !== 1'b0 || nzcv !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_op: got v=%b r=%h bt=%b nzcv=%b want 0/0/0/0000",
                     out_valid, out_result, branch_taken, nzcv);
        end
        set_idle();
    endtask

    task automatic test_subs_then_bcond();
        logic [15:0] exp_tbl;
        exp_tbl = 16'hE6A5;
        set_idle();
        in_valid      = 1'b1;
        set_flags     = 1'b1;
        alu_result    = 64'd0;
        alu_zero      = 1'b1;
        alu_carry_out = 1'b1;
        tick();
        tests_run++;
        if (nzcv !== 4'b0110) begin
            tests_failed++;
            $display("[TB] FAIL subs_nzcv: got %b want 0110", nzcv);
        end
        // every condition code against Z=1 C=1
        for (int i = 0; i < 16; i++) begin
            set_idle();
            in_valid   = 1'b1;
            is_bcond   = 1'b1;
            cond       = 4'(i);
            alu_result = 64'(i + 100);
            tick();
            tests_run++;
            if (branch_taken !== exp_tbl[i] || out_valid !== 1'b1 || out_result !== 64'(i + 100)) begin
                tests_failed++;
                $display("[TB] FAIL bcond_zc cond=%0d: got bt=%b v=%b r=%0d want bt=%b v=1 r=%0d",
                         i, branch_taken, out_valid, out_result, exp_tbl[i], i + 100);
            end
        end
        // not a live instruction: no branch even for AL
        set_idle();
        is_bcond = 1'b1;
        cond     = 4'b1110;
        tick();
        tests_run++;
        if (branch_taken !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bcond_invalid: got bt=%b v=%b want 0/0", branch_taken, out_valid);
        end
        set_idle();
    endtask

    task automatic test_same_cycle_hazard();
        load_flags(4'b0000);
        tests_run++;
        if (nzcv !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL hazard_pre_nzcv: got %b want 0000", nzcv);
        end
        set_idle();
        in_valid  = 1'b1;
        set_flags = 1'b1;
        alu_zero  = 1'b1;
        is_bcond  = 1'b1;
        cond      = 4'b0000;
        tick();
        tests_run++;
        if (branch_taken !== 1'b0 || nzcv !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL hazard_same_cycle: got bt=%b nzcv=%b want 0/0100", branch_taken, nzcv);
        end
        // the very next B.cond sees the new flags
        set_idle();
        in_valid = 1'b1;
        is_bcond = 1'b1;
        cond     = 4'b0000;
        tick();
        tests_run++;
        if (branch_taken !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL hazard_next_cycle: got bt=%b want 1", branch_taken);
        end
        set_idle();
    endtask

    task automatic test_signed_compare();
        logic [15:0] exp_tbl;
        exp_tbl = 16'hD65A;
        load_flags(4'b1001);
        tests_run++;
        if (nzcv !== 4'b1001) begin
            tests_failed++;
            $display("[TB] FAIL signed_nzcv: got %b want 1001", nzcv);
        end
        // every condition code against N=1 V=1
        for (int i = 0; i < 16; i++) begin
            set_idle();
            in_valid = 1'b1;
            is_bcond = 1'b1;
            cond     = 4'(i);
            tick();
            tests_run++;
            if (branch_taken !== exp_tbl[i]) begin
                tests_failed++;
                $display("[TB] FAIL bcond_nv cond=%0d: got bt=%b want %b", i, branch_taken, exp_tbl[i]);
            end
        end
        set_idle();
    endtask

    task automatic test_cbz();
        logic exp_cbz;
        logic exp_cbnz;
`ifdef CBZ_EN
        exp_cbz  = 1'b1;
        exp_cbnz = 1'b0;
`else
        exp_cbz  = 1'b0;
        exp_cbnz = 1'b1;
`endif
        load_flags(4'b0100);
        // CBZ with zero result, B.cond NE would say not taken
        set_idle();
        in_valid = 1'b1;
        is_cbz   = 1'b1;
        alu_zero = 1'b1;
        is_bcond = 1'b1;
        cond     = 4'b0001;
        tick();
        tests_run++;
        if (branch_taken !== exp_cbz) begin
            tests_failed++;
            $display("[TB] FAIL cbz_priority: got bt=%b want %b", branch_taken, exp_cbz);
        end
        // CBNZ with zero result, B.cond EQ would say taken
        set_idle();
        in_valid = 1'b1;
        is_cbnz  = 1'b1;
        alu_zero = 1'b1;
        is_bcond = 1'b1;
        cond     = 4'b0000;
        tick();
        tests_run++;
        if (branch_taken !== exp_cbnz) begin
            tests_failed++;
            $display("[TB] FAIL cbnz_priority: got bt=%b want %b", branch_taken, exp_cbnz);
        end
        // CBNZ with nonzero result, no B.cond
        set_idle();
        in_valid = 1'b1;
        is_cbnz  = 1'b1;
        alu_zero = 1'b0;
        tick();
        tests_run++;
`ifdef CBZ_EN
        if (branch_taken !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL cbnz_nonzero: got bt=%b want 1", branch_taken);
        end
`else
        if (branch_taken !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL cbnz_nonzero: got bt=%b want 0", branch_taken);
        end
`endif
        set_idle();
    endtask

    task automatic test_stall_flush();
        load_flags(4'b1010);
        set_idle();
        in_valid   = 1'b1;
        alu_result = 64'hDEAD_BEEF;
        is_bcond   = 1'b1;
        cond       = 4'b0010;
        tick();
        tests_run++;
        if (out_result !== 64'hDEAD_BEEF || out_valid !== 1'b1 || branch_taken !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL stall_load: got r=%h v=%b bt=%b want deadbeef/1/1",
                     out_result, out_valid, branch_taken);
        end
        for (int i = 0; i < 3; i++) begin
            set_idle();
            stall         = 1'b1;
            in_valid      = 1'b0;
            set_flags     = 1'b1;
            alu_zero      = 1'b1;
            alu_result    = 64'(i + 1) * 64'h1111;
            tick();
            tests_run++;
            if (out_result !== 64'hDEAD_BEEF || out_valid !== 1'b1 || branch_taken !== 1'b1 || nzcv !== 4'b1010) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold%0d: got r=%h v=%b bt=%b nzcv=%b want deadbeef/1/1/1010",
                         i, out_result, out_valid, branch_taken, nzcv);
            end
        end
        // flush wins over stall, flags untouched even with set_flags high
        set_idle();
        stall      = 1'b1;
        flush      = 1'b1;
        in_valid   = 1'b1;
        set_flags  = 1'b1;
        alu_zero   = 1'b1;
        alu_result = 64'h42;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_result !== 64'd0 || branch_taken !== 1'b0 || nzcv !== 4'b1010) begin
            tests_failed++;
            $display("[TB] FAIL stall_flush: got v=%b r=%h bt=%b nzcv=%b want 0/0/0/1010",
                     out_valid, out_result, branch_taken, nzcv);
        end
        // resume: bubble still passes the result bus through
        set_idle();
        alu_result = 64'h0123_4567_89AB_CDEF;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_result !== 64'h0123_4567_89AB_CDEF || nzcv !== 4'b1010) begin
            tests_failed++;
            $display("[TB] FAIL resume_bubble: got v=%b r=%h nzcv=%b want 0/0123456789abcdef/1010",
                     out_valid, out_result, nzcv);
        end
        set_idle();
    endtask

    // Run every scenario in order, then summarise
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        set_idle();
        test_reset();
        test_subs_then_bcond();
        test_same_cycle_hazard();
        test_signed_compare();
        test_cbz();
        test_stall_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_flags_stage.md
# alu_flags_stage

Execute-to-memory stage register directly downstream of the 64-bit ALU in the ARM datapath. Captures the ALU result and its four flags each cycle, maintains the architectural NZCV register for flag-setting instructions, and resolves conditional branches (B.cond, and optionally CBZ/CBNZ) into a registered taken signal. It supports stall and flush, so the same block serves the single-cycle core and a later pipelined core.

## Interface
- No parameters.
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  ALU outputs this cycle belong to a live instruction
- alu_result  input  64  ALU result bus
- alu_negative  input  1  ALU negative flag
- alu_zero  input  1  ALU zero flag
- alu_overflow  input  1  ALU overflow flag
- alu_carry_out  input  1  ALU carry-out (subtract: 1 = no borrow)
- set_flags  input  1  instruction writes NZCV (ADDS/SUBS)
- is_bcond  input  1  instruction is B.cond
- is_cbz  input  1  instruction is CBZ (ALU in pass-B mode)
- is_cbnz  input  1  instruction is CBNZ (ALU in pass-B mode)
- cond  input  4  B.cond condition code
- stall  input  1  hold all state
- flush  input  1  kill instruction in this stage
- out_valid  output  1  registered in_valid
- out_result  output  64  registered alu_result
- branch_taken  output  1  registered branch decision
- nzcv  output  4  architectural flags {N,Z,C,V}

## Operation
- Reset (sync, on rising edge with reset=1): out_valid=0, out_result=0, branch_taken=0, nzcv=4'b0000. Reset overrides stall and flush.
- Priority per edge: reset > flush > stall > normal.
- Flush: out_valid←0, branch_taken←0, out_result←0, nzcv unchanged.
- Stall: every register holds.
- Normal, in_valid=0: out_valid←0, branch_taken←0, out_result←alu_result, nzcv unchanged.
- Normal, in_valid=1: out_valid←1, out_result←alu_result. If set_flags=1, then nzcv←{alu_negative, alu_zero, alu_carry_out, alu_overflow}.
- Branch decision (in_valid=1, normal): priority is_cbz > is_cbnz > is_bcond; none asserted → 0.
  - CBZ: taken = alu_zero. CBNZ: taken = !alu_zero. Both use the live ALU flag, not nzcv.
  - B.cond: evaluated against nzcv as held *before* this edge. If set_flags=1 in the same cycle, the new flags are not seen.
- Condition codes: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 1 (ARMv8: behaves as AL).
- No arithmetic is performed; flags are stored bit-exact from the ALU.

## Timing
- Latency 1 cycle: inputs sampled at edge k appear on out_* and branch_taken after edge k.
- nzcv written at edge k is visible to a B.cond sampled at edge k+1 (no bubble).
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Deasserting stall resumes with the held values; nothing is lost or duplicated.

## Configuration
- CBZ_EN defined: is_cbz and is_cbnz are decoded as described above.
- CBZ_EN undefined: is_cbz and is_cbnz are ignored. branch_taken comes only from is_bcond, and the compare-and-branch logic is not synthesised.

## Test plan
- Reset mid-operation: set nzcv=1111, assert reset for 1 cycle with in_valid=1 and stall=1 → next cycle nzcv=0000, out_valid=0, out_result=0, branch_taken=0.
- SUBS 5−5: alu_zero=1, carry=1, set_flags=1 → nzcv=0110. Next cycle B.cond EQ (0000) → branch_taken=1. NE (0001) → 0. HI (1000) → 0.
- Same-cycle hazard: nzcv=0000, set_flags=1 with alu_zero=1, is_bcond=1, cond=EQ → branch_taken=0 and nzcv=0100 after the edge.
- Signed compare: alu_negative=1, alu_overflow=1 set → GE (1010) taken=1, LT taken=0, GT taken=1.
- CBZ_EN defined: is_cbz=1, alu_zero=1, is_bcond=1, cond=NE, nzcv Z=1 → branch_taken=1 (CBZ wins). CBZ_EN undefined: same stimulus → branch_taken=0.
- Stall/flush: out_result=0xDEAD_BEEF held through 3 stall cycles while alu_result changes. Then stall=1 and flush=1 together → out_valid=0, out_result=0, nzcv unchanged.
